// File: rtl/sll_iter_unit.sv
// Multi-cycle logical left shifter (SLL/SLLI): at most STEP positions per clock, valid/ready on both sides.
// Optional macro SLL_ZERO_BYPASS_EN: a zero shift amount skips the SHIFT state and goes straight to DONE.
module sll_iter_unit #(
  parameter int unsigned N    = 32,
  parameter int unsigned SH_W = 5,
  parameter int unsigned STEP = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [N-1:0]    i_data_in,
  input  logic [SH_W-1:0] i_shift,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [N-1:0]    o_data_out,
  output logic            o_busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [SH_W-1:0] STEP_REM = SH_W'(STEP);

  state_t          r_state;
  logic [N-1:0]    r_acc;
  logic [SH_W-1:0] r_rem;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_busy;

  logic            w_more;

  // Another full STEP is needed only while the remainder exceeds it
  assign w_more = (r_rem > STEP_REM);

  // State, datapath and Moore outputs are all updated together so the outputs stay registered
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_rem       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else if (i_flush) begin
      r_state     <= S_IDLE;
      r_rem       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_acc      <= i_data_in;
            r_rem      <= i_shift;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
`ifdef SLL_ZERO_BYPASS_EN
            if (i_shift == '0) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state     <= S_SHIFT;
            end
`else
            r_state    <= S_SHIFT;
`endif
          end
        end
        S_SHIFT: begin
          if (w_more) begin
            r_acc <= r_acc << STEP;
            r_rem <= r_rem - STEP_REM;
          end else begin
            r_acc       <= r_acc << r_rem;
            r_rem       <= '0;
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          // Result held until the consumer takes it; no same-cycle re-accept
          if (i_out_ready) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_rem       <= '0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_busy      = r_busy;
  assign o_data_out  = r_acc;

endmodule

// File: tb/tb_sll_iter_unit.sv
// Directed self-checking bench for sll_iter_unit with a result scoreboard.
module tb_sll_iter_unit;

  localparam int unsigned N    = 32;
  localparam int unsigned SH_W = 5;
  localparam int unsigned STEP = 4;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [N-1:0]    data_in;
  logic [SH_W-1:0] shift;
  logic            out_valid;
  logic            out_ready;
  logic [N-1:0]    data_out;
  logic            busy;

  int checks;
  int failures;
  logic [N-1:0] sb_q[$];

  sll_iter_unit #(.N(N), .SH_W(SH_W), .STEP(STEP)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_flush     (flush),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_data_in   (data_in),
    .i_shift     (shift),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_data_out  (data_out),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Edges from the accept edge (inclusive) until OUT_VALID is seen
  function automatic int exp_lat(input logic [SH_W-1:0] sh);
    int cyc;
    cyc = (int'(sh) + int'(STEP) - 1) / int'(STEP);
    if (cyc < 1) cyc = 1;
`ifdef SLL_ZERO_BYPASS_EN
    if (sh == '0) return 1;
`endif
    return cyc + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand and return after the accept edge
  task automatic start_op(input logic [N-1:0] d, input logic [SH_W-1:0] sh);
    data_in  = d;
    shift    = sh;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    data_in  = $urandom;
    shift    = SH_W'($urandom);
  endtask

  task automatic wait_valid(input string tag, input int exp_edges);
    int edges;
    edges = 1;
    while (!out_valid && edges < 40) begin
      tick();
      edges++;
    end
    check({tag, "_latency"}, 32'(edges), 32'(exp_edges));
  endtask

  task automatic pickup_check(input string tag);
    logic [N-1:0] exp;
    exp = 'x;
    if (sb_q.size() > 0) exp = sb_q.pop_front();
    check({tag, "_data"}, data_out, exp);
    out_ready = 1'b1;
    tick();
    check({tag, "_ready_after"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_valid_after"}, {31'd0, out_valid}, 32'd0);
  endtask

  task automatic do_op(input string tag, input logic [N-1:0] d, input logic [SH_W-1:0] sh);
    sb_q.push_back(d << sh);
    out_ready = 1'b1;
    start_op(d, sh);
    wait_valid(tag, exp_lat(sh));
    pickup_check(tag);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    data_in   = '0;
    shift     = '0;
    out_ready = 1'b0;

    tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_data", data_out, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    do_op("basic", 32'h0000_0001, 5'd31);
    do_op("fill", 32'hF000_000F, 5'd5);
    do_op("zero", 32'hDEAD_BEEF, 5'd0);
    do_op("step4", 32'h8000_0001, 5'd4);

    // Backpressure: result must stay put and DONE must ignore new operands
    sb_q.push_back(32'h2345_6780);
    out_ready = 1'b0;
    start_op(32'h1234_5678, 5'd4);
    wait_valid("bp", exp_lat(5'd4));
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      data_in  = 32'hFFFF_FFFF;
      shift    = 5'd1;
      tick();
      check("bp_valid_held", {31'd0, out_valid}, 32'd1);
      check("bp_data_held", data_out, 32'h2345_6780);
    end
    in_valid = 1'b0;
    pickup_check("bp");
    check("bp_single_pickup_busy", {31'd0, busy}, 32'd0);

    // Flush in the third SHIFT cycle
    out_ready = 1'b1;
    start_op(32'h0000_0001, 5'd31);
    tick();
    check("abort_busy_mid", {31'd0, busy}, 32'd1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_acc_kept", data_out, 32'h0000_0100);
    for (int i = 0; i < 4; i++) begin
      check("abort_no_valid", {31'd0, out_valid}, 32'd0);
      tick();
    end
    // Flush wins over acceptance in IDLE
    data_in  = 32'h5555_5555;
    shift    = 5'd1;
    in_valid = 1'b1;
    flush    = 1'b1;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    check("flush_blocks_accept", {31'd0, busy}, 32'd0);
    do_op("post_abort", 32'h0000_0003, 5'd2);

    // Asynchronous reset between edges mid-SHIFT
    start_op(32'h0000_0001, 5'd31);
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_data", data_out, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("arst_held_valid", {31'd0, out_valid}, 32'd0);
      check("arst_held_data", data_out, 32'd0);
    end
    rst_n = 1'b1;
    tick();
    check("arst_release_idle", {31'd0, in_ready}, 32'd1);
    check("arst_release_valid", {31'd0, out_valid}, 32'd0);
    do_op("after_rst", 32'hA5A5_A5A5, 5'd8);
    do_op("max_both", 32'hFFFF_FFFF, 5'd31);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sll_iter_unit.md
Name: sll_iter_unit

Overview:
- Multi-cycle logical left shifter (SLL/SLLI) for the Stage3 ALU block.
- It is the left-direction counterpart of the combinational arithmetic right-shift path.
- Shifts by at most STEP bit positions per clock, so a full 32-bit barrel network is not needed.
- A valid/ready handshake on the input and on the output lets the ALU controller stall it.

Parameters:
- N, 32, data width in bits.
- SH_W, 5, shift-amount width; must equal clog2(N).
- STEP, 4, maximum bit positions shifted per clock; range 1..N-1.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RSTN  in  1  reset, asynchronous, active-low.
- FLUSH  in  1  synchronous abort of any operation in flight.
- IN_VALID  in  1  operand presented.
- IN_READY  out  1  unit can accept an operand.
- DATA_IN  in  N  value to shift.
- SHIFT  in  SH_W  shift amount, unsigned.
- OUT_VALID  out  1  result available.
- OUT_READY  in  1  consumer takes the result.
- DATA_OUT  out  N  shifted result.
- BUSY  out  1  high in SHIFT or DONE.

Behaviour:
- Reset (RSTN low, asynchronous):
  - state = IDLE; acc = 0; rem = 0.
  - IN_READY = 1; OUT_VALID = 0; DATA_OUT = 0; BUSY = 0.
- States: IDLE, SHIFT, DONE. Outputs are decoded from the state only (Moore):
  - IN_READY = (state == IDLE).
  - OUT_VALID = (state == DONE).
  - BUSY = (state != IDLE).
  - DATA_OUT = acc, in every state.
- IDLE: an operand is accepted when IN_VALID && IN_READY at a clock edge. On acceptance:
  - acc <= DATA_IN; rem <= SHIFT.
  - Next state is SHIFT (see the optional feature for SHIFT = 0).
- SHIFT, one update per clock edge:
  - If rem > STEP: acc <= acc << STEP; rem <= rem - STEP; stay in SHIFT.
  - Otherwise: acc <= acc << rem; rem <= 0; go to DONE.
  - Shifting always zero-fills from the LSB; bits shifted past bit N-1 are discarded.
- Cycles spent in SHIFT = max(1, ceil(SHIFT/STEP)). Examples with STEP = 4: SHIFT 0 → 1, 4 → 1, 5 → 2, 31 → 8.
- Latency: OUT_VALID rises after that many clock edges following the accept edge.
- DONE:
  - acc is held stable while OUT_READY is low; backpressure is unlimited.
  - On OUT_READY high at an edge the unit returns to IDLE. OUT_VALID and BUSY drop and IN_READY rises in the next cycle.
  - A new operand cannot be accepted in the same cycle as result pickup, because IN_READY is low in DONE.
- DATA_IN and SHIFT are ignored outside IDLE. The operand is captured only on the accept edge.
- FLUSH high at an edge:
  - Forces state = IDLE and rem = 0 from any state; acc is left unchanged.
  - FLUSH has priority over acceptance, shifting and result pickup.
  - FLUSH in IDLE together with IN_VALID means no acceptance.
- RSTN asserted mid-operation immediately clears everything to the reset values. No partial result is ever presented.
- rem is SH_W bits wide and cannot underflow, because subtraction occurs only when rem > STEP.

Optional Feature:
- Macro: SLL_ZERO_BYPASS_EN.
- Defined: an accepted operand with SHIFT == 0 goes directly IDLE → DONE with acc = DATA_IN. OUT_VALID is high in the cycle after the accept edge (latency 1 edge). All other shift amounts behave as above.
- Undefined: SHIFT == 0 spends one cycle in SHIFT (shift by 0), so OUT_VALID rises 2 edges after acceptance.
- Result values are identical either way.

Test Plan:
- Basic: DATA_IN=0x00000001, SHIFT=31, OUT_READY=1 → OUT_VALID after 8 edges in SHIFT, DATA_OUT=0x80000000; IN_READY high again the following cycle.
- Fill and discard: DATA_IN=0xF000000F, SHIFT=5 → 2 SHIFT cycles, DATA_OUT=0x000001E0 (upper bits discarded, zeros filled).
- Backpressure: DATA_IN=0x12345678, SHIFT=4, OUT_READY low for 10 cycles → OUT_VALID and DATA_OUT=0x23456780 stable throughout; IN_VALID pulses during DONE are ignored; release gives one pickup.
- Zero shift: DATA_IN=0xDEADBEEF, SHIFT=0 → DATA_OUT=0xDEADBEEF. OUT_VALID after 1 edge with SLL_ZERO_BYPASS_EN, after 2 edges without.
- Abort:
  - FLUSH during SHIFT (SHIFT=31, 3rd cycle) → IDLE next cycle; OUT_VALID never asserted.
  - Then DATA_IN=0x3, SHIFT=2 → DATA_OUT=0x0000000C.
- Async reset: RSTN low mid-SHIFT, between clock edges → IN_READY=1, OUT_VALID=0, BUSY=0, DATA_OUT=0 immediately; stays so until RSTN high and a new accept.
